// File: rtl/stack_n_pkg.sv
// Shared constants for the parametrised return-address stack: command
// encodings, overflow-mode selectors and the default entry width.
package stack_n_pkg;

    localparam int PC_WIDTH = 11;

    localparam int STK_MODE_WRAP = 0;
    localparam int STK_MODE_SAT  = 1;

    typedef enum logic [1:0] {
        STK_NOP  = 2'b00,
        STK_PUSH = 2'b01,
        STK_POP  = 2'b10,
        STK_REPL = 2'b11
    } stk_cmd_e;

endpackage

// File: rtl/stack_n.sv
// Return-address stack with configurable depth, wrap or saturate overflow,
// replace-top command and sticky overflow/underflow status.
module stack_n
    import stack_n_pkg::*;
#(
    parameter int PC_WIDTH = stack_n_pkg::PC_WIDTH,
    parameter int DEPTH    = 2,
    parameter int MODE     = STK_MODE_WRAP
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 commandIn,
    input  logic [PC_WIDTH-1:0]        in,
    input  logic                       clrErr,
    output logic [PC_WIDTH-1:0]        topOut,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [PW-1:0] P_ONE   = PW'(1);
    localparam logic [CW-1:0] C_ONE   = CW'(1);
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
    localparam bit IS_WRAP = (MODE == STK_MODE_WRAP);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("stack_n: DEPTH must be a power of two and at least 2");
    end

    logic [PW-1:0]       ptr_reg, ptr_next;
    logic [CW-1:0]       count_reg, count_next;
    logic                overflow_reg, overflow_next;
    logic                underflow_reg, underflow_next;
    logic                wr_en;
    logic [PW-1:0]       wr_addr;
    logic [PC_WIDTH-1:0] level_q [DEPTH];
    logic                is_empty, is_full;
    logic                set_ovf, set_unf;
    stk_cmd_e            cmd;

    assign cmd      = stk_cmd_e'(commandIn);
    assign is_empty = (count_reg == '0);
    assign is_full  = (count_reg == C_DEPTH);

    // Each level is its own register with a decoded write enable.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_level
        logic [PC_WIDTH-1:0] lvl_reg;
        always_ff @(posedge clk) begin
            if (rst) begin
                lvl_reg <= '0;
            end else if (wr_en && wr_addr == PW'(gi)) begin
                lvl_reg <= in;
            end
        end
        assign level_q[gi] = lvl_reg;
    end

    always_comb begin
        ptr_next   = ptr_reg;
        count_next = count_reg;
        wr_en      = 1'b0;
        wr_addr    = ptr_reg;
        set_ovf    = 1'b0;
        set_unf    = 1'b0;
        unique case (cmd)
            STK_PUSH: begin
                if (!is_full) begin
                    wr_en      = 1'b1;
                    ptr_next   = ptr_reg + P_ONE;
                    count_next = count_reg + C_ONE;
                end else begin
                    set_ovf = 1'b1;
                    if (IS_WRAP) begin
                        wr_en    = 1'b1;
                        ptr_next = ptr_reg + P_ONE;
                    end
                end
            end
            STK_POP: begin
                if (!is_empty) begin
                    ptr_next   = ptr_reg - P_ONE;
                    count_next = count_reg - C_ONE;
                end else begin
                    set_unf = 1'b1;
                    if (IS_WRAP) begin
                        ptr_next = ptr_reg - P_ONE;
                    end
                end
            end
            STK_REPL: begin
                wr_en = 1'b1;
                if (is_empty) begin
                    // An empty stack has no top to replace, so REPL acts as PUSH.
                    ptr_next   = ptr_reg + P_ONE;
                    count_next = count_reg + C_ONE;
                end else begin
                    wr_addr = ptr_reg - P_ONE;
                end
            end
            default: ;
        endcase
        overflow_next  = set_ovf | (overflow_reg  & ~clrErr);
        underflow_next = set_unf | (underflow_reg & ~clrErr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg       <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            ptr_reg       <= ptr_next;
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    assign topOut    = level_q[ptr_reg - P_ONE];
    assign count     = count_reg;
    assign empty     = is_empty;
    assign full      = is_full;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;

endmodule

// File: tb/tb_stack_n.sv
// Directed bench: a WRAP and a SAT instance (DEPTH=4) driven with identical
// commands, each compared against hand-computed state.
module tb_stack_n;
    import stack_n_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  commandIn;
    logic [10:0] in;
    logic        clrErr;

    logic [10:0] top_w, top_s;
    logic [2:0]  cnt_w, cnt_s;
    logic        empty_w, empty_s, full_w, full_s;
    logic        ovf_w, ovf_s, unf_w, unf_s;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    stack_n #(.PC_WIDTH(11), .DEPTH(4), .MODE(STK_MODE_WRAP)) dut_wrap (
        .clk(clk), .rst(rst), .commandIn(commandIn), .in(in), .clrErr(clrErr),
        .topOut(top_w), .count(cnt_w), .empty(empty_w), .full(full_w),
        .overflow(ovf_w), .underflow(unf_w)
    );

    stack_n #(.PC_WIDTH(11), .DEPTH(4), .MODE(STK_MODE_SAT)) dut_sat (
        .clk(clk), .rst(rst), .commandIn(commandIn), .in(in), .clrErr(clrErr),
        .topOut(top_s), .count(cnt_s), .empty(empty_s), .full(full_s),
        .overflow(ovf_s), .underflow(unf_s)
    );

    // Packed view: {topOut, count, empty, full, overflow, underflow}
    logic [17:0] st_w, st_s;
    assign st_w = {top_w, cnt_w, empty_w, full_w, ovf_w, unf_w};
    assign st_s = {top_s, cnt_s, empty_s, full_s, ovf_s, unf_s};

    function automatic logic [17:0] st(input logic [10:0] t, input logic [2:0] c,
                                       input logic o, input logic u);
        return {t, c, (c == 3'd0), (c == 3'd4), o, u};
    endfunction

    // Apply one command for one clock; outputs are sampled 1 time unit after the edge.
    task automatic issue(input logic [1:0] c, input logic [10:0] d, input logic clr);
        commandIn = c;
        in        = d;
        clrErr    = clr;
        @(posedge clk);
        #1;
        commandIn = STK_NOP;
        in        = '0;
        clrErr    = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        issue(STK_NOP, 11'h0, 1'b0);
        issue(STK_NOP, 11'h0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++;
        if (st_w !== st(11'h0, 3'd0, 1'b0, 1'b0))
            $display("FAIL reset_wrap: got %h exp %h", st_w, st(11'h0, 3'd0, 1'b0, 1'b0));
        else pass_cnt++;
        total_cnt++;
        if (st_s !== st(11'h0, 3'd0, 1'b0, 1'b0))
            $display("FAIL reset_sat: got %h exp %h", st_s, st(11'h0, 3'd0, 1'b0, 1'b0));
        else pass_cnt++;
        rst = 1'b1;
        issue(STK_PUSH, 11'h123, 1'b0);
        rst = 1'b0;
        total_cnt++;
        if (st_w !== st(11'h0, 3'd0, 1'b0, 1'b0))
            $display("FAIL reset_with_push: got %h exp %h", st_w, st(11'h0, 3'd0, 1'b0, 1'b0));
        else pass_cnt++;
        $display("test_reset done: wrap=%h sat=%h", st_w, st_s);
    endtask

    task automatic test_lifo();
        logic [10:0] pop_exp [4] = '{11'h102, 11'h101, 11'h100, 11'h103};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            issue(STK_PUSH, 11'h100 + 11'(i), 1'b0);
            total_cnt++;
            if (st_w !== st(11'h100 + 11'(i), 3'(i + 1), 1'b0, 1'b0))
                $display("FAIL lifo_push%0d: got %h exp %h", i, st_w,
                         st(11'h100 + 11'(i), 3'(i + 1), 1'b0, 1'b0));
            else pass_cnt++;
            $display("push %h -> top=%h count=%0d", 11'h100 + 11'(i), top_w, cnt_w);
        end
        for (int i = 0; i < 4; i++) begin
            issue(STK_POP, 11'h0, 1'b0);
            total_cnt++;
            if (st_w !== st(pop_exp[i], 3'(3 - i), 1'b0, 1'b0))
                $display("FAIL lifo_pop%0d: got %h exp %h", i, st_w,
                         st(pop_exp[i], 3'(3 - i), 1'b0, 1'b0));
            else pass_cnt++;
            $display("pop -> top=%h count=%0d", top_w, cnt_w);
        end
    endtask

    task automatic test_overflow_underflow();
        logic [10:0] pw [4] = '{11'h004, 11'h003, 11'h002, 11'h005};
        logic [10:0] ps [4] = '{11'h003, 11'h002, 11'h001, 11'h004};
        do_reset();
        for (int i = 1; i <= 5; i++) issue(STK_PUSH, 11'(i), 1'b0);
        total_cnt++;
        if (st_w !== st(11'h005, 3'd4, 1'b1, 1'b0))
            $display("FAIL wrap_overflow: got %h exp %h", st_w, st(11'h005, 3'd4, 1'b1, 1'b0));
        else pass_cnt++;
        total_cnt++;
        if (st_s !== st(11'h004, 3'd4, 1'b1, 1'b0))
            $display("FAIL sat_overflow: got %h exp %h", st_s, st(11'h004, 3'd4, 1'b1, 1'b0));
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            issue(STK_POP, 11'h0, 1'b0);
            total_cnt++;
            if (st_w !== st(pw[i], 3'(3 - i), 1'b1, 1'b0))
                $display("FAIL wrap_pop%0d: got %h exp %h", i, st_w, st(pw[i], 3'(3 - i), 1'b1, 1'b0));
            else pass_cnt++;
            total_cnt++;
            if (st_s !== st(ps[i], 3'(3 - i), 1'b1, 1'b0))
                $display("FAIL sat_pop%0d: got %h exp %h", i, st_s, st(ps[i], 3'(3 - i), 1'b1, 1'b0));
            else pass_cnt++;
        end
        issue(STK_POP, 11'h0, 1'b0);
        total_cnt++;
        if (st_w !== st(11'h004, 3'd0, 1'b1, 1'b1))
            $display("FAIL wrap_underflow: got %h exp %h", st_w, st(11'h004, 3'd0, 1'b1, 1'b1));
        else pass_cnt++;
        total_cnt++;
        if (st_s !== st(11'h004, 3'd0, 1'b1, 1'b1))
            $display("FAIL sat_underflow: got %h exp %h", st_s, st(11'h004, 3'd0, 1'b1, 1'b1));
        else pass_cnt++;
        $display("underflow pop: wrap=%h sat=%h", st_w, st_s);
    endtask

    task automatic test_err_clear();
        // Flags from the previous test are still set here.
        issue(STK_NOP, 11'h0, 1'b1);
        total_cnt++;
        if ({ovf_w, unf_w, ovf_s, unf_s} !== 4'b0000)
            $display("FAIL err_clear: got %b exp 0000", {ovf_w, unf_w, ovf_s, unf_s});
        else pass_cnt++;
        for (int i = 0; i < 4; i++) issue(STK_PUSH, 11'h010 + 11'(i), 1'b0);
        issue(STK_PUSH, 11'h020, 1'b1);
        total_cnt++;
        if (st_w !== st(11'h020, 3'd4, 1'b1, 1'b0))
            $display("FAIL err_set_wins_wrap: got %h exp %h", st_w, st(11'h020, 3'd4, 1'b1, 1'b0));
        else pass_cnt++;
        total_cnt++;
        if (st_s !== st(11'h013, 3'd4, 1'b1, 1'b0))
            $display("FAIL err_set_wins_sat: got %h exp %h", st_s, st(11'h013, 3'd4, 1'b1, 1'b0));
        else pass_cnt++;
        $display("clrErr with overflowing push: ovf_w=%b ovf_s=%b", ovf_w, ovf_s);
    endtask

    task automatic test_repl();
        do_reset();
        issue(STK_PUSH, 11'h0AA, 1'b0);
        issue(STK_REPL, 11'h0BB, 1'b0);
        total_cnt++;
        if (st_w !== st(11'h0BB, 3'd1, 1'b0, 1'b0))
            $display("FAIL repl_top: got %h exp %h", st_w, st(11'h0BB, 3'd1, 1'b0, 1'b0));
        else pass_cnt++;
        issue(STK_POP, 11'h0, 1'b0);
        issue(STK_REPL, 11'h0CC, 1'b0);
        total_cnt++;
        if (st_w !== st(11'h0CC, 3'd1, 1'b0, 1'b0))
            $display("FAIL repl_empty_wrap: got %h exp %h", st_w, st(11'h0CC, 3'd1, 1'b0, 1'b0));
        else pass_cnt++;
        total_cnt++;
        if (st_s !== st(11'h0CC, 3'd1, 1'b0, 1'b0))
            $display("FAIL repl_empty_sat: got %h exp %h", st_s, st(11'h0CC, 3'd1, 1'b0, 1'b0));
        else pass_cnt++;
        $display("repl on empty: top=%h count=%0d", top_w, cnt_w);
    endtask

    initial begin
        rst       = 1'b1;
        commandIn = STK_NOP;
        in        = '0;
        clrErr    = 1'b0;
        #2;
        test_reset();
        test_lifo();
        test_overflow_underflow();
        test_err_clear();
        test_repl();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
